// File: rtl/afifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO write side.
// Grants one requester at a time for up to MAX_BURST words and never writes while wr_full is high.
module afifo_wr_arbiter #(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int CNTW      = 16
) (
    input  logic                      wr_clk,
    input  logic                      wr_rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DSIZE-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      wr_full,
    output logic [DSIZE-1:0]          wr_data,
    output logic                      wr_inc,
    output logic [$clog2(NREQ)-1:0]   cur_owner,
    output logic                      grant_active,
    output logic [CNTW-1:0]           wr_count
);

    localparam int OW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q;
    logic [OW-1:0]     owner_q;
    logic [OW-1:0]     rr_ptr_q;
    logic [BW-1:0]     burst_cnt_q;
    logic [CNTW-1:0]   wr_count_q;

    logic              owner_valid;
    logic              xfer;
    logic              scan_hit;
    logic [OW-1:0]     scan_idx;
    logic [OW-1:0]     owner_nxt;
    logic              burst_last;

    assign owner_valid = req_valid[owner_q];
    assign xfer        = (state_q == BURST) && owner_valid && !wr_full && !wr_rst;
    assign owner_nxt   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign burst_last  = (burst_cnt_q == BW'(MAX_BURST - 1));

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!scan_hit && req_valid[(int'(rr_ptr_q) + i) % NREQ]) begin
                scan_hit = 1'b1;
                scan_idx = OW'((int'(rr_ptr_q) + i) % NREQ);
            end
        end
    end

    always_comb begin
        wr_inc    = xfer;
        req_ready = '0;
        wr_data   = '0;
        if (xfer) begin
            req_ready[owner_q] = 1'b1;
            wr_data            = req_data[int'(owner_q) * DSIZE +: DSIZE];
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            wr_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_hit) begin
                        owner_q     <= scan_idx;
                        burst_cnt_q <= '0;
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                        wr_count_q  <= wr_count_q + 1'b1;
                    end
                    // A stalled owner (full FIFO, valid held) keeps the grant indefinitely.
                    if ((xfer && burst_last) || !owner_valid) begin
                        rr_ptr_q <= owner_nxt;
                        state_q  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign cur_owner    = owner_q;
    assign grant_active = (state_q == BURST);
    assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Self-checking bench for afifo_wr_arbiter: directed scenarios plus randomized traffic
// compared against a grant/words-used reference model.
module tb_afifo_wr_arbiter;

    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int MAX_BURST = 4;
    localparam int CNTW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        wr_rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic        wr_full = 1'b0;
    logic [3:0]  req_ready;
    logic [7:0]  wr_data;
    logic        wr_inc;
    logic [1:0]  cur_owner;
    logic        grant_active;
    logic [15:0] wr_count;

    logic        rst4 = 1'b1;
    logic [3:0]  v4 = '0;
    logic [31:0] d4 = 32'h44332211;
    logic [3:0]  ready4;
    logic [7:0]  data4;
    logic        inc4;
    logic [1:0]  owner4;
    logic        ga4;
    logic [3:0]  cnt4;

    afifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST), .CNTW(CNTW)) u_dut (
        .wr_clk(clk), .wr_rst(wr_rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wr_full(wr_full), .wr_data(wr_data), .wr_inc(wr_inc),
        .cur_owner(cur_owner), .grant_active(grant_active), .wr_count(wr_count)
    );

    afifo_wr_arbiter #(.DSIZE(8), .NREQ(4), .MAX_BURST(1), .CNTW(4)) u_dut4 (
        .wr_clk(clk), .wr_rst(rst4), .req_valid(v4), .req_data(d4),
        .req_ready(ready4), .wr_full(1'b0), .wr_data(data4), .wr_inc(inc4),
        .cur_owner(owner4), .grant_active(ga4), .wr_count(cnt4)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [DSIZE-1:0] exp_q[$];

    // Reference model: who holds the grant, how many words it has used, where the next search starts.
    bit          m_granted = 1'b0;
    int          m_owner = 0;
    int          m_next = 0;
    int          m_words = 0;
    int unsigned m_count = 0;

    always @(posedge clk) begin
        if (wr_rst) begin
            m_granted = 1'b0; m_owner = 0; m_next = 0; m_words = 0; m_count = 0;
        end else if (!m_granted) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!m_granted && req_valid[(m_next + i) % NREQ]) begin
                    m_granted = 1'b1; m_owner = (m_next + i) % NREQ; m_words = 0;
                end
            end
        end else begin
            bit wrote;
            wrote = req_valid[m_owner] && !wr_full;
            if (wrote) begin
                m_words = m_words + 1;
                m_count = (m_count + 1) % (1 << CNTW);
            end
            if ((wrote && m_words == MAX_BURST) || !req_valid[m_owner]) begin
                m_granted = 1'b0;
                m_next = (m_owner + 1) % NREQ;
            end
        end
    end

    function automatic logic m_xfer();
        return m_granted && req_valid[m_owner] && !wr_full && !wr_rst;
    endfunction

    task automatic do_reset();
        wr_rst = 1'b1; req_valid = '0; wr_full = 1'b0;
        @(posedge clk); #1;
        wr_rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'hF; req_data = 32'h3322115A; wr_rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++; if (wr_inc !== 1'b0) $display("FAIL rst_wr_inc: got %0h expected 0", wr_inc); else n_pass++;
        n_chk++; if (req_ready !== 4'h0) $display("FAIL rst_req_ready: got %0h expected 0", req_ready); else n_pass++;
        n_chk++; if (wr_data !== 8'h00) $display("FAIL rst_wr_data: got %0h expected 0", wr_data); else n_pass++;
        n_chk++; if (cur_owner !== 2'd0) $display("FAIL rst_cur_owner: got %0h expected 0", cur_owner); else n_pass++;
        n_chk++; if (grant_active !== 1'b0) $display("FAIL rst_grant_active: got %0h expected 0", grant_active); else n_pass++;
        n_chk++; if (wr_count !== 16'd0) $display("FAIL rst_wr_count: got %0h expected 0", wr_count); else n_pass++;
        @(posedge clk); #1;
        wr_rst = 1'b0;
        @(negedge clk);
        n_chk++; if (wr_inc !== 1'b0) $display("FAIL rst_bubble: got %0h expected 0", wr_inc); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++; if (wr_inc !== 1'b1) $display("FAIL rst_first_write: got %0h expected 1", wr_inc); else n_pass++;
        n_chk++; if (req_ready !== 4'b0001) $display("FAIL rst_first_ready: got %0h expected 1", req_ready); else n_pass++;
        n_chk++; if (wr_data !== 8'h5A) $display("FAIL rst_first_data: got %0h expected 5a", wr_data); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_single_requester();
        logic [7:0] pat;
        int idx;
        pat = 8'b11011110;
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 6; k++) exp_q.push_back(8'hA0 + 8'(k));
        idx = 0;
        req_valid = 4'b0010; req_data = '0; req_data[15:8] = 8'hA0;
        for (int c = 0; c < 8; c++) begin
            logic took;
            @(negedge clk);
            took = wr_inc;
            n_chk++; if (wr_inc !== pat[c]) $display("FAIL single_inc c%0d: got %0h expected %0h", c, wr_inc, pat[c]); else n_pass++;
            if (wr_inc === 1'b1 && exp_q.size() > 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                n_chk++; if (wr_data !== e) $display("FAIL single_data c%0d: got %0h expected %0h", c, wr_data, e); else n_pass++;
                n_chk++; if (req_ready !== 4'b0010) $display("FAIL single_ready c%0d: got %0h expected 2", c, req_ready); else n_pass++;
            end
            @(posedge clk); #1;
            if (took === 1'b1) begin
                idx++;
                if (idx == 6) req_valid = '0; else req_data[15:8] = 8'hA0 + 8'(idx);
            end
        end
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++; if (wr_count !== 16'd6) $display("FAIL single_count: got %0d expected 6", wr_count); else n_pass++;
        n_chk++; if (cur_owner !== 2'd1) $display("FAIL single_owner: got %0d expected 1", cur_owner); else n_pass++;
        n_chk++; if (grant_active !== 1'b0) $display("FAIL single_idle: got %0h expected 0", grant_active); else n_pass++;
        n_chk++; if (exp_q.size() != 0) $display("FAIL single_left: got %0d expected 0", exp_q.size()); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_all_active();
        do_reset();
        req_valid = 4'hF; req_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        for (int c = 0; c < 25; c++) begin
            int own;
            logic wr_ex;
            own = (c / 5) % 4;
            wr_ex = ((c % 5) != 0);
            @(negedge clk);
            n_chk++; if (wr_inc !== wr_ex) $display("FAIL all_inc c%0d: got %0h expected %0h", c, wr_inc, wr_ex); else n_pass++;
            if (wr_ex) begin
                n_chk++; if (wr_data !== 8'hC0 + 8'(own)) $display("FAIL all_data c%0d: got %0h expected %0h", c, wr_data, 8'hC0 + 8'(own)); else n_pass++;
                n_chk++; if (cur_owner !== 2'(own)) $display("FAIL all_owner c%0d: got %0d expected %0d", c, cur_owner, own); else n_pass++;
                n_chk++; if (req_ready !== 4'(1 << own)) $display("FAIL all_ready c%0d: got %0h expected %0h", c, req_ready, 4'(1 << own)); else n_pass++;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
    endtask

    task automatic test_full_stall();
        logic [7:0] pat;
        int idx;
        pat = 8'b11000110;
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(8'hB0 + 8'(k));
        idx = 0;
        req_valid = 4'b0100; req_data = '0; req_data[23:16] = 8'hB0;
        for (int c = 0; c < 8; c++) begin
            logic took;
            wr_full = (c >= 3 && c <= 5);
            @(negedge clk);
            took = wr_inc;
            n_chk++; if (wr_inc !== pat[c]) $display("FAIL stall_inc c%0d: got %0h expected %0h", c, wr_inc, pat[c]); else n_pass++;
            if (wr_full) begin
                n_chk++; if (req_ready !== 4'h0) $display("FAIL stall_ready c%0d: got %0h expected 0", c, req_ready); else n_pass++;
                n_chk++; if (cur_owner !== 2'd2) $display("FAIL stall_owner c%0d: got %0d expected 2", c, cur_owner); else n_pass++;
                n_chk++; if (grant_active !== 1'b1) $display("FAIL stall_grant c%0d: got %0h expected 1", c, grant_active); else n_pass++;
            end
            if (wr_inc === 1'b1 && exp_q.size() > 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                n_chk++; if (wr_data !== e) $display("FAIL stall_data c%0d: got %0h expected %0h", c, wr_data, e); else n_pass++;
            end
            @(posedge clk); #1;
            if (took === 1'b1) begin
                idx++;
                if (idx == 4) req_valid = '0; else req_data[23:16] = 8'hB0 + 8'(idx);
            end
        end
        wr_full = 1'b0;
        @(negedge clk);
        n_chk++; if (grant_active !== 1'b0) $display("FAIL stall_release: got %0h expected 0", grant_active); else n_pass++;
        n_chk++; if (wr_count !== 16'd4) $display("FAIL stall_count: got %0d expected 4", wr_count); else n_pass++;
        n_chk++; if (exp_q.size() != 0) $display("FAIL stall_left: got %0d expected 0", exp_q.size()); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_valid_drop();
        logic [9:0] pat;
        pat = 10'b1011110010;
        do_reset();
        req_valid = 4'b1001; req_data = {8'h73, 8'h72, 8'h71, 8'h70};
        for (int c = 0; c < 10; c++) begin
            int own;
            own = (c == 1 || c == 9) ? 0 : 3;
            if (c == 2) req_valid = 4'b1000;
            if (c == 3) req_valid = 4'b1001;
            @(negedge clk);
            n_chk++; if (wr_inc !== pat[c]) $display("FAIL drop_inc c%0d: got %0h expected %0h", c, wr_inc, pat[c]); else n_pass++;
            if (pat[c]) begin
                n_chk++; if (cur_owner !== 2'(own)) $display("FAIL drop_owner c%0d: got %0d expected %0d", c, cur_owner, own); else n_pass++;
                n_chk++; if (wr_data !== 8'h70 + 8'(own)) $display("FAIL drop_data c%0d: got %0h expected %0h", c, wr_data, 8'h70 + 8'(own)); else n_pass++;
            end
            if (c == 2) begin
                n_chk++; if (grant_active !== 1'b1) $display("FAIL drop_grant: got %0h expected 1", grant_active); else n_pass++;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
    endtask

    task automatic test_count_wrap();
        int seen;
        rst4 = 1'b1; v4 = '0;
        @(posedge clk); #1;
        rst4 = 1'b0; v4 = 4'hF;
        seen = 0;
        for (int c = 0; c < 200 && seen < 17; c++) begin
            @(negedge clk);
            if (inc4 === 1'b1) begin
                seen++;
                if (seen == 17) begin
                    n_chk++; if (cnt4 !== 4'd0) $display("FAIL wrap_at16: got %0d expected 0", cnt4); else n_pass++;
                end
            end
            @(posedge clk); #1;
        end
        v4 = '0;
        n_chk++; if (seen != 17) $display("FAIL wrap_writes: got %0d expected 17", seen); else n_pass++;
        @(negedge clk);
        n_chk++; if (cnt4 !== 4'd1) $display("FAIL wrap_count: got %0d expected 1", cnt4); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid = 4'b0100; req_data = '0; req_data[23:16] = 8'hE0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        wr_rst = 1'b1;
        @(negedge clk);
        n_chk++; if (wr_inc !== 1'b0) $display("FAIL midrst_inc: got %0h expected 0", wr_inc); else n_pass++;
        n_chk++; if (req_ready !== 4'h0) $display("FAIL midrst_ready: got %0h expected 0", req_ready); else n_pass++;
        n_chk++; if (wr_data !== 8'h00) $display("FAIL midrst_data: got %0h expected 0", wr_data); else n_pass++;
        @(posedge clk); #1;
        wr_rst = 1'b0; req_valid = '0;
        @(negedge clk);
        n_chk++; if (cur_owner !== 2'd0) $display("FAIL midrst_owner: got %0d expected 0", cur_owner); else n_pass++;
        n_chk++; if (grant_active !== 1'b0) $display("FAIL midrst_grant: got %0h expected 0", grant_active); else n_pass++;
        n_chk++; if (wr_count !== 16'd0) $display("FAIL midrst_count: got %0d expected 0", wr_count); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [3:0] acc;
        acc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            wr_rst  = ($urandom_range(0, 99) == 0);
            wr_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !acc[i] && $urandom_range(0, 15) != 0)) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_data[i*8 +: 8] = 8'($urandom);
                end
            end
            @(negedge clk);
            n_chk++; if (wr_inc !== m_xfer()) $display("FAIL rnd_inc %0d: got %0h expected %0h", cyc, wr_inc, m_xfer()); else n_pass++;
            n_chk++; if (req_ready !== (m_xfer() ? 4'(1 << m_owner) : 4'h0)) $display("FAIL rnd_ready %0d: got %0h expected %0h", cyc, req_ready, m_xfer() ? 4'(1 << m_owner) : 4'h0); else n_pass++;
            n_chk++; if (wr_data !== (m_xfer() ? req_data[m_owner*8 +: 8] : 8'h00)) $display("FAIL rnd_data %0d: got %0h expected %0h", cyc, wr_data, m_xfer() ? req_data[m_owner*8 +: 8] : 8'h00); else n_pass++;
            n_chk++; if (cur_owner !== 2'(m_owner)) $display("FAIL rnd_owner %0d: got %0d expected %0d", cyc, cur_owner, m_owner); else n_pass++;
            n_chk++; if (grant_active !== m_granted) $display("FAIL rnd_grant %0d: got %0h expected %0h", cyc, grant_active, m_granted); else n_pass++;
            n_chk++; if (wr_count !== 16'(m_count)) $display("FAIL rnd_count %0d: got %0d expected %0d", cyc, wr_count, m_count); else n_pass++;
            acc = m_xfer() ? 4'(1 << m_owner) : 4'h0;
            @(posedge clk); #1;
        end
        wr_rst = 1'b0; wr_full = 1'b0; req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_requester();
        test_all_active();
        test_full_stall();
        test_valid_drop();
        test_count_wrap();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
